// File: rtl/neuron_mac_ctrl_if.sv
// Operand/result bus between the layer scheduler, the neuron sequencer and the
// layer output buffer. The master drives the evaluation, the slave is the sequencer.
interface neuron_mac_ctrl_if;
    logic        start;
    logic [31:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] w;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        d;
    logic        busy;

    modport master (
        output start,
        output bias,
        output in_valid,
        output x,
        output w,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  d,
        input  busy
    );

    modport slave (
        input  start,
        input  bias,
        input  in_valid,
        input  x,
        input  w,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output d,
        output busy
    );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// Single-neuron Q16.16 evaluation: acc = bias + sum(x*w) over N_IN streamed pairs,
// then y = relu(acc) and d = (acc > 0) are presented with a valid/ready handshake.
module neuron_mac_ctrl #(
    parameter int unsigned N_IN = 16
) (
    input logic              clk,
    input logic              rst_n,
    neuron_mac_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StAct,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      y_q, y_d;
    logic             d_q, d_d;

    logic signed [63:0] x_ext;
    logic signed [63:0] w_ext;
    logic signed [63:0] prod_full;
    logic [31:0]        prod;
    logic               acc_pos;
    logic               unused_prod_bits;

    // Full signed product; keeping bits [47:16] floors toward -inf and wraps on overflow.
    always_comb begin
        x_ext     = {{32{bus.x[31]}}, bus.x};
        w_ext     = {{32{bus.w[31]}}, bus.w};
        prod_full = x_ext * w_ext;
        prod      = prod_full[47:16];
        acc_pos   = ($signed(acc_q) > 32'sd0);
    end

    assign unused_prod_bits = ^{prod_full[63:48], prod_full[15:0]};

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            d_q     <= d_d;
        end
    end

    // Next-state and datapath update; start is only looked at in idle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        d_d     = d_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StAcc;
                    acc_d   = bus.bias;
                    cnt_d   = '0;
                end
            end
            StAcc: begin
                if (bus.in_valid) begin
                    acc_d = acc_q + prod;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastIdx) begin
                        state_d = StAct;
                    end
                end
            end
            StAct: begin
                y_d     = acc_pos ? acc_q : 32'd0;
                d_d     = acc_pos;
                state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        bus.in_ready  = (state_q == StAcc);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.y         = y_q;
        bus.d         = d_q;
    end
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed bench for neuron_mac_ctrl: one instance with N_IN=4, one with N_IN=2.
module tb_neuron_mac_ctrl;
    logic clk;
    logic rst_n;

    neuron_mac_ctrl_if bus4 ();
    neuron_mac_ctrl_if bus2 ();

    neuron_mac_ctrl #(.N_IN(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    neuron_mac_ctrl #(.N_IN(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] vx [4];
    logic [31:0] vw [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic rd_in_ready(input bit s2);
        return s2 ? bus2.in_ready : bus4.in_ready;
    endfunction

    function automatic logic rd_out_valid(input bit s2);
        return s2 ? bus2.out_valid : bus4.out_valid;
    endfunction

    function automatic logic rd_busy(input bit s2);
        return s2 ? bus2.busy : bus4.busy;
    endfunction

    function automatic logic [31:0] rd_y(input bit s2);
        return s2 ? bus2.y : bus4.y;
    endfunction

    function automatic logic rd_d(input bit s2);
        return s2 ? bus2.d : bus4.d;
    endfunction

    task automatic set_start(input bit s2, input logic v);
        if (s2) bus2.start = v;
        else    bus4.start = v;
    endtask

    task automatic set_pair(input logic v, input logic [31:0] xv, input logic [31:0] wv);
        bus4.in_valid = v;
        bus2.in_valid = v;
        bus4.x = xv;
        bus2.x = xv;
        bus4.w = wv;
        bus2.w = wv;
    endtask

    task automatic set_out_ready(input logic v);
        bus4.out_ready = v;
        bus2.out_ready = v;
    endtask

    // Entered and left on a falling edge with the selected DUT idle.
    task automatic run_eval(input string nm, input bit s2, input logic [31:0] b,
                            input int duty, input bit poke, input int hold,
                            input bit start_at_ack, input bit chk_timing,
                            input logic [31:0] exp_y, input logic exp_d);
        int n;
        int k;
        int guard;
        int rdy;
        n = s2 ? 2 : 4;
        k = 0;
        guard = 0;
        rdy = 0;
        check_eq({nm, "_idle_in_ready"}, 32'(rd_in_ready(s2)), 32'd0);
        check_eq({nm, "_idle_busy"}, 32'(rd_busy(s2)), 32'd0);
        set_start(s2, 1'b1);
        bus4.bias = b;
        bus2.bias = b;
        @(negedge clk);
        set_start(s2, 1'b0);
        while (k < n && guard < 400) begin
            bit v;
            v = ($urandom_range(99) < duty);
            if (v) set_pair(1'b1, vx[k], vw[k]);
            else   set_pair(1'b0, $urandom, $urandom);
            set_start(s2, (poke && guard == 2) ? 1'b1 : 1'b0);
            if (rd_in_ready(s2)) begin
                rdy++;
                if (v) k++;
            end
            @(negedge clk);
            guard++;
        end
        set_pair(1'b0, 32'd0, 32'd0);
        set_start(s2, 1'b0);
        check_eq({nm, "_accepted"}, 32'(k), 32'(n));
        if (chk_timing) begin
            check_eq({nm, "_in_ready_cycles"}, 32'(rdy), 32'(n));
            check_eq({nm, "_act_out_valid"}, 32'(rd_out_valid(s2)), 32'd0);
            check_eq({nm, "_act_in_ready"}, 32'(rd_in_ready(s2)), 32'd0);
        end
        @(negedge clk);
        check_eq({nm, "_out_valid"}, 32'(rd_out_valid(s2)), 32'd1);
        check_eq({nm, "_y"}, rd_y(s2), exp_y);
        check_eq({nm, "_d"}, 32'(rd_d(s2)), 32'(exp_d));
        for (int i = 0; i < hold; i++) begin
            set_out_ready(1'b0);
            @(negedge clk);
            check_eq({nm, "_hold_out_valid"}, 32'(rd_out_valid(s2)), 32'd1);
            check_eq({nm, "_hold_y"}, rd_y(s2), exp_y);
            check_eq({nm, "_hold_d"}, 32'(rd_d(s2)), 32'(exp_d));
            check_eq({nm, "_hold_in_ready"}, 32'(rd_in_ready(s2)), 32'd0);
            check_eq({nm, "_hold_busy"}, 32'(rd_busy(s2)), 32'd1);
        end
        set_out_ready(1'b1);
        set_start(s2, start_at_ack);
        @(negedge clk);
        set_out_ready(1'b0);
        set_start(s2, 1'b0);
        check_eq({nm, "_ack_out_valid"}, 32'(rd_out_valid(s2)), 32'd0);
        check_eq({nm, "_ack_busy"}, 32'(rd_busy(s2)), 32'd0);
        check_eq({nm, "_ack_y_kept"}, rd_y(s2), exp_y);
    endtask

    task automatic load4(input logic [31:0] xv, input logic [31:0] wv);
        for (int i = 0; i < 4; i++) begin
            vx[i] = xv;
            vw[i] = wv;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus4.start = 1'b0;
        bus2.start = 1'b0;
        bus4.bias = '0;
        bus2.bias = '0;
        set_pair(1'b0, 32'd0, 32'd0);
        set_out_ready(1'b0);
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(bus4.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check_eq("rst_y", bus4.y, 32'd0);
        check_eq("rst_d", 32'(bus4.d), 32'd0);
        check_eq("rst_busy", 32'(bus4.busy), 32'd0);
        check_eq("rst2_busy", 32'(bus2.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal: 4 x (1.0 * 0.5) = 2.0
        load4(32'h0001_0000, 32'h0000_8000);
        run_eval("nom", 1'b0, 32'h0, 100, 1'b0, 0, 1'b0, 1'b1, 32'h0002_0000, 1'b1);

        // -1.0 + 4 x (-0.25) = -2.0, and 1.0 + 4 x (-0.25) = 0
        load4(32'h0001_0000, 32'hFFFF_C000);
        run_eval("neg", 1'b0, 32'hFFFF_0000, 100, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_eval("zero", 1'b0, 32'h0001_0000, 100, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Floor truncation: prods are 0xFFFFFFFF and 0
        vx[0] = 32'hFFFF_FFFF; vw[0] = 32'h0000_8000;
        vx[1] = 32'h0000_0001; vw[1] = 32'h0000_8000;
        run_eval("trunc", 1'b1, 32'h0, 100, 1'b0, 0, 1'b0, 1'b1, 32'h0, 1'b0);
        run_eval("trunc_b2", 1'b1, 32'h2, 100, 1'b0, 0, 1'b0, 1'b0, 32'h1, 1'b1);

        // Wrap: 32767.0 * 2.0 wraps to 0xFFFE0000
        vx[0] = 32'h7FFF_0000; vw[0] = 32'h0002_0000;
        vx[1] = 32'h0000_0000; vw[1] = 32'h1234_5678;
        run_eval("wrap", 1'b1, 32'h0, 100, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_eval("wrap_b3", 1'b1, 32'h0003_0000, 100, 1'b0, 0, 1'b0, 1'b0, 32'h0001_0000, 1'b1);

        // Sparse in_valid, stray start in ACC, consumer stalls 5 cycles
        load4(32'h0001_0000, 32'h0000_8000);
        run_eval("stress", 1'b0, 32'h0, 40, 1'b1, 5, 1'b0, 1'b0, 32'h0002_0000, 1'b1);

        // Reset after two of four pairs
        bus4.start = 1'b1;
        bus4.bias = 32'h5555_0000;
        @(negedge clk);
        bus4.start = 1'b0;
        set_pair(1'b1, 32'h0001_0000, 32'h0000_8000);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_pair(1'b0, 32'd0, 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus4.in_ready), 32'd0);
        check_eq("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check_eq("mid_rst_y", bus4.y, 32'd0);
        check_eq("mid_rst_d", 32'(bus4.d), 32'd0);
        check_eq("mid_rst_busy", 32'(bus4.busy), 32'd0);
        run_eval("post_rst", 1'b0, 32'h0, 100, 1'b0, 0, 1'b0, 1'b1, 32'h0002_0000, 1'b1);

        // Back-to-back: start during the DONE handshake is ignored
        run_eval("b2b_a", 1'b0, 32'h0, 100, 1'b0, 0, 1'b1, 1'b0, 32'h0002_0000, 1'b1);
        run_eval("b2b_b", 1'b0, 32'h0001_0000, 100, 1'b0, 0, 1'b0, 1'b1, 32'h0003_0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
